tm_multimaster_credit_arbiter: RTL

//  Shares one NoC injection port between NUM_REQ master bundles. Each request carries its own dest/vc.

---
 rtl/tm_multimaster_credit_arbiter_pkg.sv | 21 ++
 rtl/tm_multimaster_credit_arbiter_if.sv | 35 +++
 rtl/tm_multimaster_credit_arbiter_rr.sv | 31 +++
 rtl/tm_multimaster_credit_arbiter.sv | 109 ++++++++++
 4 files changed

// File: rtl/tm_multimaster_credit_arbiter_pkg.sv
// Shared types and width helpers for the multi-master credit arbiter.
// Other files pick these up with import tm_arb_pkg::*.
package tm_arb_pkg;

    localparam int DEF_ADDRESS_WIDTH    = 4;
    localparam int DEF_VC_ADDRESS_WIDTH = 2;

    typedef struct packed {
        logic [DEF_VC_ADDRESS_WIDTH-1:0] vc;
        logic [DEF_ADDRESS_WIDTH-1:0]    dest;
    } dst_t;

    function automatic int cnt_width(input int num_credits);
        return $clog2(num_credits + 1);
    endfunction

    function automatic int id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/tm_multimaster_credit_arbiter_if.sv
// Master-side request bundles, NoC injection port and reply return path.
interface tm_multimaster_credit_arbiter_if
    import tm_arb_pkg::*;
#(
    parameter int NUM_REQ          = 4,
    parameter int ADDRESS_WIDTH    = 4,
    parameter int VC_ADDRESS_WIDTH = 2,
    parameter int WIDTH_NOC        = 36
);
    localparam int IDW = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]                  req_valid;
    logic [NUM_REQ-1:0]                  req_ready;
    logic [NUM_REQ*WIDTH_NOC-1:0]        req_data;
    logic [NUM_REQ*ADDRESS_WIDTH-1:0]    req_dest;
    logic [NUM_REQ*VC_ADDRESS_WIDTH-1:0] req_vc;
    logic                                noc_ready_in;
    logic                                noc_valid_out;
    logic [WIDTH_NOC-1:0]                noc_data_out;
    logic [ADDRESS_WIDTH-1:0]            noc_dest_out;
    logic [VC_ADDRESS_WIDTH-1:0]         noc_vc_out;
    logic                                rsp_valid;
    logic [IDW-1:0]                      rsp_req_id;

    modport master (
        output req_valid, req_data, req_dest, req_vc, noc_ready_in, rsp_valid, rsp_req_id,
        input  req_ready, noc_valid_out, noc_data_out, noc_dest_out, noc_vc_out
    );

    modport slave (
        input  req_valid, req_data, req_dest, req_vc, noc_ready_in, rsp_valid, rsp_req_id,
        output req_ready, noc_valid_out, noc_data_out, noc_dest_out, noc_vc_out
    );

endinterface

// File: rtl/tm_multimaster_credit_arbiter_rr.sv
// Combinational round-robin picker: first eligible index at or after rr_ptr, wrapping.
module tm_rr_arbiter
    import tm_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]           eligible,
    input  logic [id_width(NUM_REQ)-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]           grant,
    output logic [id_width(NUM_REQ)-1:0] grant_idx,
    output logic                         grant_any
);
    localparam int IDW = id_width(NUM_REQ);

    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!grant_any && eligible[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = IDW'(idx);
                grant_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tm_multimaster_credit_arbiter.sv
// Shares one NoC injection port among NUM_REQ masters with per-master credit
// tracking and a destination lock while replies are outstanding.
module tm_multimaster_credit_arbiter
    import tm_arb_pkg::*;
#(
    parameter int NUM_REQ          = 4,
    parameter int NUM_CREDITS      = 32,
    parameter int ADDRESS_WIDTH    = 4,
    parameter int VC_ADDRESS_WIDTH = 2,
    parameter int WIDTH_NOC        = 36
) (
    input logic clk,
    input logic rst,
    tm_multimaster_credit_arbiter_if.slave bus
);
    localparam int CW  = cnt_width(NUM_CREDITS);
    localparam int IDW = id_width(NUM_REQ);
    localparam int AW  = ADDRESS_WIDTH;
    localparam int VW  = VC_ADDRESS_WIDTH;
    localparam int DW  = AW + VW;
    localparam logic [CW-1:0] FULL_CNT = CW'(NUM_CREDITS);

    logic [CW-1:0]      outstanding [NUM_REQ];
    logic [DW-1:0]      last_dst    [NUM_REQ];
    logic [DW-1:0]      dst         [NUM_REQ];
    logic [IDW-1:0]     rr_ptr;
    logic [NUM_REQ-1:0] eligible, grant, rsp_hit;
    logic [IDW-1:0]     grant_idx;
    logic               grant_any;
    logic               underflow;

    logic                 vld_p1;
    logic [WIDTH_NOC-1:0] data_p1;
    logic [AW-1:0]        dest_p1;
    logic [VW-1:0]        vc_p1;

    // Eligibility uses registered counters only; a reply frees a credit next cycle.
    always_comb begin
        underflow = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            dst[i]      = {bus.req_vc[i*VW +: VW], bus.req_dest[i*AW +: AW]};
            eligible[i] = bus.req_valid[i] & bus.noc_ready_in & ~rst
                        & (outstanding[i] < FULL_CNT)
                        & ((outstanding[i] == '0) | (dst[i] == last_dst[i]));
            rsp_hit[i]  = bus.rsp_valid & (int'(bus.rsp_req_id) == i);
            underflow   = underflow | (rsp_hit[i] & ~grant[i] & (outstanding[i] == '0));
        end
    end

    tm_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .eligible  (eligible),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign bus.req_ready = grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                outstanding[i] <= '0;
                last_dst[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i] && !rsp_hit[i])
                    outstanding[i] <= outstanding[i] + 1'b1;
                else if (!grant[i] && rsp_hit[i] && outstanding[i] != '0)
                    outstanding[i] <= outstanding[i] - 1'b1;
                if (grant[i])
                    last_dst[i] <= dst[i];
            end
            if (grant_any)
                rr_ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    // Stage p1: registered flit toward the fabric, zeroed when nothing was granted.
    always_ff @(posedge clk) begin
        if (rst || !grant_any) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            dest_p1 <= '0;
            vc_p1   <= '0;
        end else begin
            vld_p1  <= 1'b1;
            data_p1 <= bus.req_data[int'(grant_idx)*WIDTH_NOC +: WIDTH_NOC];
            dest_p1 <= bus.req_dest[int'(grant_idx)*AW +: AW];
            vc_p1   <= bus.req_vc[int'(grant_idx)*VW +: VW];
        end
    end

    assign bus.noc_valid_out = vld_p1;
    assign bus.noc_data_out  = data_p1;
    assign bus.noc_dest_out  = dest_p1;
    assign bus.noc_vc_out    = vc_p1;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && underflow)
            $warning("tm_multimaster_credit_arbiter: reply for master %0d with no outstanding request",
                     bus.rsp_req_id);
    end
`endif

endmodule
